// File: rtl/marquee_scheduler.sv
// marquee_scheduler: character ring with a 4-wide scrolling window,
// prescaled step timing, wrap hold and idle-only host writes.
module marquee_scheduler #(
    parameter int CW         = 5,
    parameter int MSG_LEN    = 8,
    parameter int DIV        = 25_000_000,
    parameter int HOLD_STEPS = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          dir,
    input  logic          load_en,
    input  logic [3:0]    load_addr,
    input  logic [CW-1:0] load_data,
    output logic [CW-1:0] q0,
    output logic [CW-1:0] q1,
    output logic [CW-1:0] q2,
    output logic [CW-1:0] q3,
    output logic          step,
    output logic          wrap,
    output logic          busy
);

    localparam int PW   = $clog2(MSG_LEN);
    localparam int CNTW = $clog2(DIV);
    localparam int HW   = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam int HLST = (HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0;

    localparam logic [PW-1:0]   LAST = PW'(MSG_LEN - 1);
    localparam logic [PW:0]     LENW = (PW + 1)'(MSG_LEN);
    localparam logic [4:0]      LEN5 = 5'(MSG_LEN);
    localparam logic [CNTW-1:0] CMAX = CNTW'(DIV - 1);
    localparam logic [HW-1:0]   HMAX = HW'(HLST);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t          state;
    logic [CNTW-1:0] cnt;
    logic [HW-1:0]   hcnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   nptr;
    logic [CW-1:0]   ring [MSG_LEN];
    logic [CW-1:0]   win  [4];
    logic [PW:0]     s;

    function automatic logic [CW-1:0] init_char(input int i);
        case (i)
            0:       return CW'(3);
            1:       return CW'(17);
            2:       return CW'(9);
            3:       return CW'(6);
            4:       return CW'(12);
            5:       return CW'(17);
            6:       return CW'(10);
            default: return CW'(15);
        endcase
    endfunction

    // Explicit wrap so non-power-of-2 ring lengths behave.
    always_comb begin
        if (dir)
            nptr = (ptr == '0) ? LAST : ptr - 1'b1;
        else
            nptr = (ptr == LAST) ? '0 : ptr + 1'b1;
    end

    always_comb begin
        s = '0;
        for (int k = 0; k < 4; k++) begin
            s = {1'b0, ptr} + (PW + 1)'(k);
            if (s >= LENW)
                s = s - LENW;
            win[k] = ring[s[PW-1:0]];
        end
    end

    assign q0 = win[0];
    assign q1 = win[1];
    assign q2 = win[2];
    assign q3 = win[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++)
                ring[i] <= init_char(i);
        end else if (load_en && state == IDLE &&
                     {1'b0, load_addr} < LEN5) begin
            ring[load_addr[PW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hcnt  <= '0;
            ptr   <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            if (stop) begin
                state <= IDLE;
                cnt   <= '0;
                hcnt  <= '0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (start) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (cnt == CMAX) begin
                            cnt  <= '0;
                            ptr  <= nptr;
                            step <= 1'b1;
                            if (nptr == '0) begin
                                wrap <= 1'b1;
                                if (HOLD_STEPS > 0) begin
                                    state <= HOLD;
                                    hcnt  <= '0;
                                end
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (cnt == CMAX) begin
                            cnt <= '0;
                            if (hcnt == HMAX) begin
                                state <= RUN;
                                hcnt  <= '0;
                            end else begin
                                hcnt <= hcnt + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_marquee_scheduler.sv
// Directed bench for marquee_scheduler with DIV=4, HOLD_STEPS=2,
// ring "FURIOUS"+blank as codes 3,17,9,6,12,17,10,15.
module tb_marquee_scheduler;

    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          dir;
    logic          load_en;
    logic [3:0]    load_addr;
    logic [CW-1:0] load_data;
    logic [CW-1:0] q0, q1, q2, q3;
    logic          step, wrap, busy;

    int total = 0;
    int bad   = 0;

    marquee_scheduler #(
        .CW(CW), .MSG_LEN(8), .DIV(4), .HOLD_STEPS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .dir(dir), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .q0(q0), .q1(q1), .q2(q2),
        .q3(q3), .step(step), .wrap(wrap), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_q(input string tag,
                         input logic [CW-1:0] a, b, c, d);
        chk(tag, 32'({q0, q1, q2, q3}), 32'({a, b, c, d}));
    endtask

    // Ticks until step (bounded), then checks latency, window, wrap.
    task automatic run_step(input string tag, input int en,
                            input logic [CW-1:0] a, b, c, d,
                            input logic ew);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (step !== 1'b1 && n < 40);
        chk({tag, "_cyc"}, 32'(n), 32'(en));
        chk_q({tag, "_q"}, a, b, c, d);
        chk({tag, "_wrap"}, 32'(wrap), 32'(ew));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        #12;
        chk_q("rst_q", 3, 17, 9, 6);
        chk("rst_step", 32'(step), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        load_en = 1'b1; load_addr = 4'd1; load_data = 5'd0;
        tick();
        load_en = 1'b0;
        chk_q("load_idle", 3, 0, 9, 6);
        load_en = 1'b1; load_addr = 4'd1; load_data = 5'd17;
        tick();
        load_en = 1'b0;
        chk_q("load_restore", 3, 17, 9, 6);
        load_en = 1'b1; load_addr = 4'd9; load_data = 5'd0;
        tick();
        load_en = 1'b0;
        chk_q("load_drop9", 3, 17, 9, 6);

        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 32'(busy), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        run_step("s1", 4, 17, 9, 6, 12, 1'b0);
        run_step("s2", 4, 9, 6, 12, 17, 1'b0);
        run_step("s3", 4, 6, 12, 17, 10, 1'b0);

        load_en = 1'b1; load_addr = 4'd1; load_data = 5'd0;
        tick();
        load_en = 1'b0;
        run_step("s4", 3, 12, 17, 10, 15, 1'b0);
        run_step("s5", 4, 17, 10, 15, 3, 1'b0);
        run_step("s6", 4, 10, 15, 3, 17, 1'b0);
        run_step("s7", 4, 15, 3, 17, 9, 1'b0);
        run_step("s8", 4, 3, 17, 9, 6, 1'b1);
        run_step("hold", 12, 17, 9, 6, 12, 1'b0);

        dir = 1'b1;
        run_step("r0", 4, 3, 17, 9, 6, 1'b1);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stophold_busy", 32'(busy), 0);
        chk_q("stophold_q", 3, 17, 9, 6);
        for (int i = 0; i < 6; i++)
            tick();
        chk("idle_step", 32'(step), 0);
        chk("idle_busy", 32'(busy), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        run_step("r7", 4, 15, 3, 17, 9, 1'b0);
        run_step("r6", 4, 10, 15, 3, 17, 1'b0);
        tick();
        tick();
        dir = 1'b0;
        run_step("dirmid", 2, 15, 3, 17, 9, 1'b0);

        tick();
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stoplast_step", 32'(step), 0);
        chk("stoplast_busy", 32'(busy), 0);
        chk_q("stoplast_q", 15, 3, 17, 9);

        load_en = 1'b1; load_addr = 4'd0; load_data = 5'd1;
        tick();
        load_en = 1'b0;
        chk_q("load_a0", 15, 1, 17, 9);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk_q("async_rst_q", 3, 17, 9, 6);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_step", 32'(step), 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 0);
        chk_q("post_rst_q", 3, 17, 9, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
